tt_um_seven_segment_fun1: RTL and testbench
===========================================

TT_UM_SEVEN_SEGMENT_FUN1 -- requirements
Module: tt_um_seven_segment_fun1

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable clock cycles required before a button level is accepted.
REQ-002 Parameter ANIM_DIV, default 16: clock cycles per animation step.
REQ-003 clk  in  1  system clock; the single clock, all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ena  in  1  tile-select; ignored.
REQ-006 ui_in  in  8  [0]=btn1 inc, [1]=btn2 dec, [2]=btn3 mode, [3]=btn4 clear, all active-high; [7:4] ignored.
REQ-007 uio_in  in  8  ignored.
REQ-008 uo_out  out  8  [6:0]=segments a..g (bit0=a), active-high; [7]=decimal point.
REQ-009 uio_out  out  8  constant 0.
REQ-010 uio_oe  out  8  constant 0 (all inputs).

Function
REQ-011 Each of ui_in[3:0] SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-012 Debouncer: accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the counter.
REQ-013 Bounces shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change and no press.
REQ-014 Press = one-cycle pulse on the 0->1 transition of the accepted level; release generates nothing.
REQ-015 State: 4-bit value (0..15) and 1-bit mode (0=HEX, 1=ANIM).
REQ-016 btn1 press: value+1 mod 16 (F->0); btn2 press: value-1 mod 16 (0->F); btn4 press: value=0.
REQ-017 Same-cycle presses: btn4 > btn1 > btn2 for value; btn3 acts independently.
REQ-018 btn3 press toggles mode; entering ANIM resets the animation position to a and its divider to 0.
REQ-019 Value and mode update on the clock edge after the press pulse.
REQ-020 HEX: uo_out[6:0] = 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 for 0..F; uo_out[7]=0.
REQ-021 ANIM: exactly one segment lit, rotating a->b->c->d->e->f->a, one step per ANIM_DIV cycles; uo_out[7]=1; value keeps updating but is not shown.
REQ-022 uo_out SHALL be combinational from registered state only (no input-to-output path).

Reset
REQ-023 rst_n low SHALL immediately clear synchronizers, debounce counters/levels, value=0, mode=HEX, animation position=a, divider=0.
REQ-024 During and after reset uo_out=0x3F; a button held through reset release is accepted only after full debounce.

Configuration
REQ-025 Macro SEVEN_SEG_ANIMATION_EN defined: btn3 and ANIM mode as above.
REQ-026 Macro undefined: no animation logic; btn3 ignored; mode constant HEX; uo_out[7]=0.

Structure
REQ-027 Package seven_seg_pkg SHALL hold the 16-entry hex segment table, the six animation segment codes, and the mode encoding.
REQ-028 One sub-module, button_debounce (synchronizer + debouncer + press pulse), instantiated four times.

Verification
REQ-029 Reset, no buttons -> uo_out=0x3F.
REQ-030 ui_in[0] toggled every 2 cycles for 16 cycles, ending low -> no press, uo_out stays 0x3F.
REQ-031 btn1 held clean 10 cycles, released, twice -> uo_out 0x06 then 0x5B; btn2 three presses -> 0x71 (wrap to F).
REQ-032 Value 5, btn1 and btn4 pressed in the same cycle -> value 0, uo_out=0x3F.
REQ-033 With SEVEN_SEG_ANIMATION_EN, btn3 press -> uo_out=0x81, after 16 cycles 0x82, after 96 back to 0x81; second btn3 press -> hex display, bit7=0.
REQ-034 rst_n asserted mid-animation with value 9 -> uo_out=0x3F immediately, without a clock edge.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment tables and display mode encoding for the seven-segment tile
package seven_seg_pkg;

    typedef enum logic {
        MODE_HEX  = 1'b0,
        MODE_ANIM = 1'b1
    } mode_e;

    // Segment codes, bit0 = a ... bit6 = g; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [5:0][6:0] ANIM_SEG = {
        7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01
    };

    localparam logic [2:0] ANIM_LAST = 3'd5;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, debouncer and rising-edge press pulse for one button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/tt_um_seven_segment_fun1.sv
// rtl/tt_um_seven_segment_fun1.sv - button-driven hex counter display; SEVEN_SEG_ANIMATION_EN adds the rotating-segment mode
module tt_um_seven_segment_fun1
    import seven_seg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ANIM_DIV        = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [3:0] press;
    logic [3:0] value_q, value_d;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (ui_in[i]),
            .press_o(press[i])
        );
    end

    // Clear wins over increment, increment over decrement.
    always_comb begin
        value_d = value_q;
        if (press[3]) begin
            value_d = 4'd0;
        end else if (press[0]) begin
            value_d = value_q + 4'd1;
        end else if (press[1]) begin
            value_d = value_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

`ifdef SEVEN_SEG_ANIMATION_EN
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    mode_e            mode_q, mode_d;
    logic [2:0]       pos_q, pos_d;
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        div_d  = div_q;
        if (press[2]) begin
            mode_d = (mode_q == MODE_HEX) ? MODE_ANIM : MODE_HEX;
            pos_d  = 3'd0;
            div_d  = '0;
        end else if (mode_q == MODE_ANIM) begin
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d = '0;
                pos_d = (pos_q == ANIM_LAST) ? 3'd0 : pos_q + 3'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_HEX;
            pos_q  <= 3'd0;
            div_q  <= '0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            div_q  <= div_d;
        end
    end

    always_comb begin
        if (mode_q == MODE_ANIM) begin
            uo_out = {1'b1, ANIM_SEG[pos_q]};
        end else begin
            uo_out = {1'b0, HEX_SEG[value_q]};
        end
    end

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
    assign uo_out = {1'b0, HEX_SEG[value_q]};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4], press[2]};
`endif

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_seven_segment_fun1.sv
// tb/tb_tt_um_seven_segment_fun1.sv - directed-vector self-checking bench for tt_um_seven_segment_fun1
module tb_tt_um_seven_segment_fun1;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int n_cmp = 0;
    int n_err = 0;

    tt_um_seven_segment_fun1 #(
        .DEBOUNCE_CYCLES(4),
        .ANIM_DIV       (16)
    ) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Clean press: 10 cycles held, 10 cycles released.
    task automatic press_btn(input logic [3:0] mask);
        ui_in[3:0] = mask;
        wait_neg(10);
        ui_in[3:0] = 4'b0000;
        wait_neg(10);
    endtask

    initial begin
        ui_in  = 8'h00;
        uio_in = 8'hA5;
        ena    = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_eq("reset_uo_out", uo_out, 8'h3F);
        check_eq("uio_out_zero", uio_out, 8'h00);
        check_eq("uio_oe_zero", uio_oe, 8'h00);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(3);
        check_eq("idle_after_reset", uo_out, 8'h3F);

        for (int i = 0; i < 4; i++) begin
            ui_in[0] = 1'b1;
            wait_neg(2);
            ui_in[0] = 1'b0;
            wait_neg(2);
        end
        ui_in[7:4] = 4'hF;
        wait_neg(12);
        check_eq("bounce_no_press", uo_out, 8'h3F);
        ui_in[7:4] = 4'h0;

        press_btn(4'b0001);
        check_eq("inc_to_1", uo_out, 8'h06);
        press_btn(4'b0001);
        check_eq("inc_to_2", uo_out, 8'h5B);
        press_btn(4'b0010);
        check_eq("dec_to_1", uo_out, 8'h06);
        press_btn(4'b0010);
        check_eq("dec_to_0", uo_out, 8'h3F);
        press_btn(4'b0010);
        check_eq("dec_wrap_F", uo_out, 8'h71);
        press_btn(4'b0001);
        check_eq("inc_wrap_0", uo_out, 8'h3F);

        for (int i = 0; i < 5; i++) press_btn(4'b0001);
        check_eq("value_5", uo_out, 8'h6D);
        press_btn(4'b1001);
        check_eq("clear_beats_inc", uo_out, 8'h3F);
        press_btn(4'b0011);
        check_eq("inc_beats_dec", uo_out, 8'h06);
        press_btn(4'b1000);
        check_eq("clear_alone", uo_out, 8'h3F);

        // Button held through reset release must still be fully debounced.
        rst_n    = 1'b0;
        ui_in[0] = 1'b1;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(4);
        check_eq("held_thru_reset_early", uo_out, 8'h3F);
        wait_neg(6);
        check_eq("held_thru_reset_late", uo_out, 8'h06);
        ui_in[0] = 1'b0;
        wait_neg(10);

`ifdef SEVEN_SEG_ANIMATION_EN
        ui_in[2] = 1'b1;
        wait_neg(7);
        check_eq("anim_enter", uo_out, 8'h81);
        wait_neg(15);
        check_eq("anim_step_boundary", uo_out, 8'h81);
        wait_neg(1);
        check_eq("anim_step_b", uo_out, 8'h82);
        wait_neg(80);
        check_eq("anim_full_cycle", uo_out, 8'h81);
        ui_in[2] = 1'b0;
        wait_neg(10);
        press_btn(4'b0001);
        check_eq("anim_dp_set", uo_out & 8'h80, 8'h80);
        press_btn(4'b0100);
        check_eq("anim_exit_hex_2", uo_out, 8'h5B);
        for (int i = 0; i < 7; i++) press_btn(4'b0001);
        check_eq("value_9", uo_out, 8'h6F);
        press_btn(4'b0100);
        check_eq("anim_reenter", uo_out, 8'h81);
`else
        press_btn(4'b0100);
        check_eq("mode_btn_ignored", uo_out, 8'h06);
        for (int i = 0; i < 8; i++) press_btn(4'b0001);
        check_eq("value_9", uo_out, 8'h6F);
`endif

        rst_n = 1'b0;
        #1;
        check_eq("async_reset", uo_out, 8'h3F);
        wait_neg(2);
        check_eq("reset_held", uo_out, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
